// File: rtl/screen_wr_seq_if.sv
// Host register-write strobe bus and screen RAM write port of screen_wr_seq.
// master = host/bench side driving register strobes; slave = the sequencer.
// Carries cursor/mode/busy status back to the host alongside the RAM write port.
interface screen_wr_seq_if;
  logic        reg_wr;
  logic [3:0]  reg_sel;
  logic [7:0]  reg_data;
  logic [7:0]  mode;
  logic [15:0] cursor_addr;
  logic [15:0] ram_wraddr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        busy;

  modport master (
    output reg_wr, reg_sel, reg_data,
    input  mode, cursor_addr, ram_wraddr, ram_data, ram_wren, busy
  );

  modport slave (
    input  reg_wr, reg_sel, reg_data,
    output mode, cursor_addr, ram_wraddr, ram_data, ram_wren, busy
  );
endinterface

// File: rtl/screen_wr_seq.sv
// Screen write sequencer: register file (mode/cursor/fill), char writes at the
// cursor with auto-increment, and a hardware clear-screen fill.
// RAM writes appear one cycle after the strobe; a clear writes one word per clk.
module screen_wr_seq #(
  parameter int COLS      = 80,
  parameter int ROWS      = 60,
  parameter int CLR_WORDS = 7680
) (
  input logic           clk,
  input logic           rst,
  screen_wr_seq_if.slave bus
);

  localparam int CW = $clog2(CLR_WORDS + 1);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t          state, next_state;
  logic [7:0]      mode_q;
  logic [7:0]      fill_q;
  logic [6:0]      x;
  logic [7:0]      y;
  logic [15:0]     addr_lin;
  logic [CW-1:0]   cnt;
  logic [15:0]     cursor;
  logic [15:0]     wraddr_q;
  logic [7:0]      wrdata_q;
  logic            wren_q;

  logic            char_wr;
  logic            start_clear;
  logic            clear_wr;
  logic            clear_done;

  // xy form packs y above a 7-bit x field; linear form is the raw 16-bit address
  assign cursor = (mode_q == 8'd0) ? {1'b0, y, x} : addr_lin;

  assign bus.mode        = mode_q;
  assign bus.cursor_addr = cursor;
  assign bus.ram_wraddr  = wraddr_q;
  assign bus.ram_data    = wrdata_q;
  assign bus.ram_wren    = wren_q;
  assign bus.busy        = (state == CLEAR);

  // FSM state register; reset aborts any running clear at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and per-cycle actions; char and clear strobes only act in IDLE
  always_comb begin
    next_state  = state;
    char_wr     = 1'b0;
    start_clear = 1'b0;
    clear_wr    = 1'b0;
    clear_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.reg_wr && bus.reg_sel == 4'd1) begin
          char_wr = 1'b1;
        end else if (bus.reg_wr && bus.reg_sel == 4'd5 && bus.reg_data == 8'h01) begin
          start_clear = 1'b1;
          next_state  = CLEAR;
        end
      end
      CLEAR: begin
        // cnt is the next address to write; word 0 was issued on entry
        if (cnt == CW'(CLR_WORDS)) begin
          clear_done = 1'b1;
          next_state = IDLE;
        end else begin
          clear_wr = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Register file, cursor movement, clear counter and the registered RAM port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 8'd0;
      fill_q   <= 8'h20;
      x        <= 7'd0;
      y        <= 8'd0;
      addr_lin <= 16'd0;
      cnt      <= '0;
      wraddr_q <= 16'd0;
      wrdata_q <= 8'd0;
      wren_q   <= 1'b0;
    end else begin
      wren_q <= 1'b0;

      // mode, cursor and fill registers are writable even during a clear
      if (bus.reg_wr) begin
        case (bus.reg_sel)
          4'd0: mode_q <= bus.reg_data;
          4'd3: begin
            x             <= bus.reg_data[6:0];
            addr_lin[7:0] <= bus.reg_data;
          end
          4'd4: begin
            y              <= bus.reg_data;
            addr_lin[15:8] <= bus.reg_data;
          end
          4'd6: fill_q <= bus.reg_data;
          default: ;
        endcase
      end

      if (char_wr) begin
        wren_q   <= 1'b1;
        wraddr_q <= cursor;
        wrdata_q <= bus.reg_data;
        if (mode_q == 8'd0) begin
          // x wraps at the last column, or at 127 when loaded out of range
          if (x == 7'(COLS - 1) || x == 7'h7f) begin
            x <= 7'd0;
            y <= (y == 8'(ROWS - 1)) ? 8'd0 : y + 8'd1;
          end else begin
            x <= x + 7'd1;
          end
        end else begin
          addr_lin <= addr_lin + 16'd1;
        end
      end

      if (start_clear) begin
        wren_q   <= 1'b1;
        wraddr_q <= 16'd0;
        wrdata_q <= fill_q;
        cnt      <= CW'(1);
      end

      // ram_data is left alone so the fill captured at entry persists
      if (clear_wr) begin
        wren_q   <= 1'b1;
        wraddr_q <= 16'(cnt);
        cnt      <= cnt + CW'(1);
      end

      // cursor reset wins over any reg3/reg4 write landing on the same edge
      if (clear_done) begin
        x        <= 7'd0;
        y        <= 8'd0;
        addr_lin <= 16'd0;
      end
    end
  end

endmodule
